mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single ktc32 memory port (`addr`/`wd`/`memwrite`/`rd`) between the CPU core and a DMA/loader master. It sits between the core top level and the memory, so both masters see an identical req/done handshake. The memory stays a plain synchronous single-port RAM. Every access is registered toward memory, and the read data is registered back to the requester.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of `clk`).
- `core_req`  in  1  core requests an access; held high and stable until `core_done`.
- `core_addr`  in  AW  core address.
- `core_wd`  in  DW  core write data.
- `core_memwrite`  in  2  00 = read; nonzero = write, size code passed to memory unmodified.
- `core_rd`  out  DW  registered read data; valid while `core_done`=1.
- `core_done`  out  1  one-cycle completion pulse.
- `dma_req`, `dma_addr`, `dma_wd`, `dma_memwrite`, `dma_rd`, `dma_done`: same as the core port, for the DMA master.
- `m_addr`  out  AW  memory address (registered).
- `m_wd`  out  DW  memory write data (registered).
- `m_memwrite`  out  2  memory write strobe/size (registered); 00 except during ISSUE.
- `m_rd`  in  DW  memory read data, valid one cycle after `m_addr` is presented.
- `owner`  out  1  0 = core, 1 = DMA; master of the current or most recent access.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. The FSM advances unconditionally except in IDLE.
- **IDLE:**
  - If neither port requests, stay in IDLE.
  - If exactly one `*_req` is high, grant that port.
  - If both are high, grant the port not equal to `last_grant`.
  - On a grant: latch the winner's addr/wd/memwrite into `m_addr`/`m_wd`/`m_memwrite`, set `owner` and `last_grant` to the winner, then go to ISSUE.
- **ISSUE:** memory sees the latched access for exactly this cycle. Next state is WAIT, and `m_memwrite` is cleared to 00.
- **WAIT:**
  - `m_rd` is valid. If the access was a read, capture `m_rd` into the owner's `*_rd` register.
  - If it was a write, `*_rd` keeps its old value.
  - Next state is DONE.
- **DONE:** assert `*_done` for the owner only, then go to IDLE.
- Reads and writes have the same latency.
- A requester must not change addr/wd/memwrite while its req is high and done has not yet pulsed. Because the fields are latched at grant, the arbiter is robust to changes after the grant.
- A `*_req` still high in the IDLE cycle after `*_done` is treated as a new access.
- Round-robin: when both ports request continuously, grants alternate core, dma, core, … No port waits more than one foreign access.
- `m_addr`/`m_wd` hold their last latched values outside ISSUE. `owner` holds until the next grant.

## Timing
- Reset values:
  - state = IDLE.
  - `core_done` = `dma_done` = 0, `busy` = 0, `m_memwrite` = 00.
  - `m_addr` = 0, `m_wd` = 0, `core_rd` = `dma_rd` = 0.
  - `owner` = 0, `last_grant` = DMA, so the core wins the first tie.
- Latency: req sampled high in IDLE at cycle T, then ISSUE at T+1, WAIT at T+2, done at T+3.
- Throughput: one access per 4 cycles. The earliest next grant is T+4.
- `busy` is high in ISSUE, WAIT and DONE.
- Reset asserted in any state takes the FSM to IDLE on that edge, clears both done outputs, and drops the pending access with no done.
  - A write whose ISSUE cycle coincides with the reset edge still reaches memory, because the memory samples the already-driven registers.
- A req arriving while `busy` is ignored until IDLE and is never lost, since the requester holds it.

## Test plan
- **Single core read:** reset released, `core_req`=1, `core_addr`=0x10, `core_memwrite`=00, memory holds 0xDEADBEEF at 0x10. Required: `m_addr`=0x10 in ISSUE, `core_done`=1 exactly 3 cycles after req sampled, `core_rd`=0xDEADBEEF, `dma_done` stays 0.
- **DMA word write:** `dma_req`=1, `dma_addr`=0x20, `dma_wd`=0x12345678, `dma_memwrite`=11. Required: `m_memwrite`=11 for exactly one cycle, memory[0x20]=0x12345678, `dma_done` pulse, `dma_rd` unchanged.
- **Contention:** both reqs held high from reset release for 4 accesses. Required: grant order core, dma, core, dma; done pulses 4 cycles apart; `owner` = 0,1,0,1.
- **Back-to-back single port:** `core_req` held high for 3 accesses. Required: `core_done` at T+3, T+7, T+11.
- **Reset mid-operation:** assert `reset`=0 in WAIT of a core read. Required: next cycle IDLE, `busy`=0, no `core_done`, `core_rd`=0; after release with `core_req` still high, a fresh access completes normally.
- **Field change after grant:** change `core_addr` from 0x10 to 0x30 in the ISSUE cycle. Required: memory accessed at 0x10 only.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous single-port memory
// between the CPU core and a DMA/loader master. Every access takes four
// cycles (IDLE grant, ISSUE, WAIT, DONE) regardless of read or write.
module mem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wd,
    input  logic [1:0]    core_memwrite,
    output logic [DW-1:0] core_rd,
    output logic          core_done,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wd,
    input  logic [1:0]    dma_memwrite,
    output logic [DW-1:0] dma_rd,
    output logic          dma_done,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wd,
    output logic [1:0]    m_memwrite,
    input  logic [DW-1:0] m_rd,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic          w_grant;
    logic          w_winner;
    logic          r_owner;
    logic          r_lastGrant;
    logic          r_isWrite;
    logic [AW-1:0] r_mAddr;
    logic [DW-1:0] r_mWd;
    logic [1:0]    r_mMemwrite;
    logic [DW-1:0] r_coreRd;
    logic [DW-1:0] r_dmaRd;

    // State register; an asserted reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state and grant decision; ties go to the port that did not win last.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_winner    = r_lastGrant;
        case (r_state)
            IDLE: begin
                if (core_req && dma_req) begin
                    w_grant  = 1'b1;
                    w_winner = ~r_lastGrant;
                end else if (core_req) begin
                    w_grant  = 1'b1;
                    w_winner = 1'b0;
                end else if (dma_req) begin
                    w_grant  = 1'b1;
                    w_winner = 1'b1;
                end
                if (w_grant) w_nextState = ISSUE;
            end
            ISSUE:   w_nextState = WAIT;
            WAIT:    w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: latch the winner's request at grant, drop the write strobe
    // after ISSUE, and capture read data for the owner during WAIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mAddr     <= '0;
            r_mWd       <= '0;
            r_mMemwrite <= 2'b00;
            r_isWrite   <= 1'b0;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_coreRd    <= '0;
            r_dmaRd     <= '0;
        end else begin
            if (w_grant) begin
                r_mAddr     <= w_winner ? dma_addr : core_addr;
                r_mWd       <= w_winner ? dma_wd : core_wd;
                r_mMemwrite <= w_winner ? dma_memwrite : core_memwrite;
                r_isWrite   <= w_winner ? (dma_memwrite != 2'b00) : (core_memwrite != 2'b00);
                r_owner     <= w_winner;
                r_lastGrant <= w_winner;
            end
            if (r_state == ISSUE) r_mMemwrite <= 2'b00;
            if (r_state == WAIT && !r_isWrite) begin
                if (r_owner) r_dmaRd  <= m_rd;
                else         r_coreRd <= m_rd;
            end
        end
    end

    assign m_addr     = r_mAddr;
    assign m_wd       = r_mWd;
    assign m_memwrite = r_mMemwrite;
    assign owner      = r_owner;
    assign core_rd    = r_coreRd;
    assign dma_rd     = r_dmaRd;
    assign busy       = (r_state != IDLE);
    assign core_done  = (r_state == DONE) && !r_owner;
    assign dma_done   = (r_state == DONE) && r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [1:0]  core_memwrite;
    logic [31:0] core_rd;
    logic        core_done;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [31:0] dma_wd;
    logic [1:0]  dma_memwrite;
    logic [31:0] dma_rd;
    logic        dma_done;
    logic [31:0] m_addr;
    logic [31:0] m_wd;
    logic [1:0]  m_memwrite;
    logic [31:0] m_rd;
    logic        owner;
    logic        busy;

    logic [31:0] mem [0:255];
    int          writeCount;
    int          cyc;
    int          checks;
    int          errors;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_addr(core_addr), .core_wd(core_wd),
        .core_memwrite(core_memwrite), .core_rd(core_rd), .core_done(core_done),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wd(dma_wd),
        .dma_memwrite(dma_memwrite), .dma_rd(dma_rd), .dma_done(dma_done),
        .m_addr(m_addr), .m_wd(m_wd), .m_memwrite(m_memwrite), .m_rd(m_rd),
        .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port RAM; known contents are loaded while reset is low.
    always @(posedge clk) begin
        if (!reset) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h30] <= 32'hCAFEF00D;
        end else if (m_memwrite != 2'b00) begin
            mem[m_addr[7:0]] <= m_wd;
        end
        m_rd <= mem[m_addr[7:0]];
    end

    // Counts memory edges that carried a write strobe.
    always @(posedge clk) begin
        if (m_memwrite != 2'b00) writeCount <= writeCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps until either done output rises; returns the number of edges taken, 0 on timeout.
    task automatic waitForDone(input int budget, output int taken);
        taken = 0;
        for (int n = 1; n <= budget; n++) begin
            step();
            if (core_done || dma_done) begin
                taken = n;
                break;
            end
        end
    endtask

    initial begin
        int taken;
        int wrBefore;
        int prevCyc;
        logic expOwner;

        checks = 0; errors = 0; cyc = 0; writeCount = 0;
        reset = 1'b0;
        core_req = 1'b0; core_addr = '0; core_wd = '0; core_memwrite = 2'b00;
        dma_req = 1'b0;  dma_addr = '0;  dma_wd = '0;  dma_memwrite = 2'b00;
        step(); step();

        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_core_done", {31'd0, core_done}, 32'd0);
        checkOutput("rst_dma_done", {31'd0, dma_done}, 32'd0);
        checkOutput("rst_m_memwrite", {30'd0, m_memwrite}, 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'd0);
        checkOutput("rst_m_wd", m_wd, 32'd0);
        checkOutput("rst_core_rd", core_rd, 32'd0);
        checkOutput("rst_dma_rd", dma_rd, 32'd0);
        checkOutput("rst_owner", {31'd0, owner}, 32'd0);
        reset = 1'b1;
        step();

        // Single core read of 0x10.
        core_req = 1'b1; core_addr = 32'h10; core_memwrite = 2'b00;
        step();
        checkOutput("rd_issue_m_addr", m_addr, 32'h10);
        checkOutput("rd_issue_busy", {31'd0, busy}, 32'd1);
        checkOutput("rd_issue_done", {31'd0, core_done}, 32'd0);
        step();
        checkOutput("rd_wait_done", {31'd0, core_done}, 32'd0);
        step();
        checkOutput("rd_core_done", {31'd0, core_done}, 32'd1);
        checkOutput("rd_core_rd", core_rd, 32'hDEADBEEF);
        checkOutput("rd_dma_done", {31'd0, dma_done}, 32'd0);
        core_req = 1'b0;
        step();
        checkOutput("rd_after_done", {31'd0, core_done}, 32'd0);
        checkOutput("rd_after_busy", {31'd0, busy}, 32'd0);

        // DMA word write to 0x20.
        wrBefore = writeCount;
        dma_req = 1'b1; dma_addr = 32'h20; dma_wd = 32'h12345678; dma_memwrite = 2'b11;
        step();
        checkOutput("wr_issue_memwrite", {30'd0, m_memwrite}, 32'd3);
        checkOutput("wr_issue_owner", {31'd0, owner}, 32'd1);
        step();
        checkOutput("wr_wait_memwrite", {30'd0, m_memwrite}, 32'd0);
        step();
        checkOutput("wr_dma_done", {31'd0, dma_done}, 32'd1);
        checkOutput("wr_core_done", {31'd0, core_done}, 32'd0);
        checkOutput("wr_dma_rd", dma_rd, 32'd0);
        checkOutput("wr_mem", mem[8'h20], 32'h12345678);
        checkOutput("wr_strobe_cycles", writeCount - wrBefore, 32'd1);
        dma_req = 1'b0; dma_memwrite = 2'b00;
        step();

        // Contention from reset release: core first, then alternating.
        reset = 1'b0;
        core_req = 1'b1; core_addr = 32'h10; core_memwrite = 2'b00;
        dma_req = 1'b1;  dma_addr = 32'h20;  dma_memwrite = 2'b00;
        step();
        reset = 1'b1;
        prevCyc = cyc;
        for (int i = 0; i < 4; i++) begin
            expOwner = (i % 2 == 1);
            waitForDone(8, taken);
            checkOutput($sformatf("rr_latency_%0d", i), cyc - prevCyc, (i == 0) ? 32'd3 : 32'd4);
            prevCyc = cyc;
            checkOutput($sformatf("rr_owner_%0d", i), {31'd0, owner}, {31'd0, expOwner});
            checkOutput($sformatf("rr_core_done_%0d", i), {31'd0, core_done}, {31'd0, !expOwner});
            checkOutput($sformatf("rr_dma_done_%0d", i), {31'd0, dma_done}, {31'd0, expOwner});
        end
        checkOutput("rr_core_rd", core_rd, 32'hDEADBEEF);
        checkOutput("rr_dma_rd", dma_rd, 32'h12345678);
        core_req = 1'b0; dma_req = 1'b0;
        step();

        // Back-to-back core reads with req held high.
        core_req = 1'b1; core_addr = 32'h10;
        prevCyc = cyc;
        for (int i = 0; i < 3; i++) begin
            waitForDone(8, taken);
            checkOutput($sformatf("b2b_done_at_%0d", i), cyc - prevCyc, 32'd3 + 32'd4 * i);
            checkOutput($sformatf("b2b_core_done_%0d", i), {31'd0, core_done}, 32'd1);
        end
        core_req = 1'b0;
        step();

        // Reset asserted during WAIT of a core read.
        core_req = 1'b1; core_addr = 32'h10;
        step(); step();
        reset = 1'b0;
        step();
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_core_done", {31'd0, core_done}, 32'd0);
        checkOutput("mid_rst_core_rd", core_rd, 32'd0);
        reset = 1'b1;
        waitForDone(8, taken);
        checkOutput("mid_rst_retry_latency", taken, 32'd3);
        checkOutput("mid_rst_retry_core_rd", core_rd, 32'hDEADBEEF);
        core_req = 1'b0;
        step();

        // Address changed after grant must not affect the access.
        core_req = 1'b1; core_addr = 32'h10;
        step();
        core_addr = 32'h30;
        checkOutput("chg_issue_m_addr", m_addr, 32'h10);
        step();
        checkOutput("chg_wait_m_addr", m_addr, 32'h10);
        step();
        checkOutput("chg_core_done", {31'd0, core_done}, 32'd1);
        checkOutput("chg_core_rd", core_rd, 32'hDEADBEEF);
        core_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
